// File: rtl/div_rr_sequencer_if.sv
// Request/response bundle for the shared iterative divider.
//   master : requester/consumer side (drives reqN_valid/operands, resp_ready)
//   slave  : divider side (drives reqN_ready, response fields, busy)
interface div_rr_sequencer_if #(
    parameter int unsigned WIDTH = 32
);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_dividend;
    logic [WIDTH-1:0] req0_divisor;
    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_dividend;
    logic [WIDTH-1:0] req1_divisor;
    logic             resp_valid;
    logic             resp_ready;
    logic             resp_id;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;
    logic             busy;

    modport master (
        output req0_valid, req0_dividend, req0_divisor,
        output req1_valid, req1_dividend, req1_divisor,
        output resp_ready,
        input  req0_ready, req1_ready,
        input  resp_valid, resp_id, quotient, remainder, div_by_zero, busy
    );

    modport slave (
        input  req0_valid, req0_dividend, req0_divisor,
        input  req1_valid, req1_dividend, req1_divisor,
        input  resp_ready,
        output req0_ready, req1_ready,
        output resp_valid, resp_id, quotient, remainder, div_by_zero, busy
    );
endinterface

// File: rtl/div_rr_sequencer.sv
// Sequencer for the shared unsigned restoring divider. Arbitrates round-robin
// between two requesters, computes one quotient bit per clock and holds the
// tagged result on a valid/ready response port.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : div_rr_sequencer_if.slave (request ports, response port, busy)
module div_rr_sequencer #(
    parameter int unsigned WIDTH = 32
) (
    input logic                clk,
    input logic                rst_n,
    div_rr_sequencer_if.slave  bus
);
    localparam int unsigned CntW = $clog2(WIDTH);
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StIter, StDone} state_e;

    state_e             state_q, state_d;
    logic               last_grant_q, last_grant_d;
    logic [WIDTH-1:0]   dvd_q, dvd_d;  // dividend shifts out the top, quotient shifts in
    logic [WIDTH-1:0]   dsr_q, dsr_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [CntW-1:0]    count_q, count_d;
    logic [WIDTH-1:0]   quotient_q, quotient_d;
    logic [WIDTH-1:0]   remainder_q, remainder_d;
    logic               resp_id_q, resp_id_d;
    logic               dbz_q, dbz_d;
    logic               busy_q, busy_d;

    logic               ready0, ready1, sel;
    logic [WIDTH-1:0]   acc_dvd, acc_dsr;
    logic [WIDTH:0]     rem_sh, rem_diff;
    logic               q_bit;
    logic [WIDTH-1:0]   rem_next;

    always_comb begin
        // Contention goes to the requester that was not granted last.
        ready0 = rst_n && (state_q == StIdle) && bus.req0_valid &&
                 (!bus.req1_valid || last_grant_q);
        ready1 = rst_n && (state_q == StIdle) && bus.req1_valid &&
                 (!bus.req0_valid || !last_grant_q);
        sel     = ready1;
        acc_dvd = sel ? bus.req1_dividend : bus.req0_dividend;
        acc_dsr = sel ? bus.req1_divisor  : bus.req0_divisor;

        rem_sh   = {rem_q, dvd_q[WIDTH-1]};
        rem_diff = rem_sh - {1'b0, dsr_q};
        q_bit    = (rem_sh >= {1'b0, dsr_q});
        rem_next = q_bit ? rem_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        dvd_d        = dvd_q;
        dsr_d        = dsr_q;
        rem_d        = rem_q;
        count_d      = count_q;
        quotient_d   = quotient_q;
        remainder_d  = remainder_q;
        resp_id_d    = resp_id_q;
        dbz_d        = dbz_q;

        unique case (state_q)
            StIdle: begin
                if (ready0 || ready1) begin
                    last_grant_d = sel;
                    dvd_d        = acc_dvd;
                    dsr_d        = acc_dsr;
                    rem_d        = '0;
                    count_d      = '0;
                    if (acc_dsr == '0) begin
                        // Skip iteration: result is fully known at accept.
                        quotient_d  = '1;
                        remainder_d = acc_dvd;
                        resp_id_d   = sel;
                        dbz_d       = 1'b1;
                        state_d     = StDone;
                    end else begin
                        state_d = StIter;
                    end
                end
            end
            StIter: begin
                dvd_d   = {dvd_q[WIDTH-2:0], q_bit};
                rem_d   = rem_next;
                count_d = count_q + CntW'(1);
                if (count_q == LastCnt) begin
                    quotient_d  = {dvd_q[WIDTH-2:0], q_bit};
                    remainder_d = rem_next;
                    resp_id_d   = last_grant_q;
                    dbz_d       = 1'b0;
                    state_d     = StDone;
                end
            end
            StDone: begin
                if (bus.resp_ready) begin
                    dbz_d   = 1'b0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            last_grant_q <= 1'b1;
            dvd_q        <= '0;
            dsr_q        <= '0;
            rem_q        <= '0;
            count_q      <= '0;
            quotient_q   <= '0;
            remainder_q  <= '0;
            resp_id_q    <= 1'b0;
            dbz_q        <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            dvd_q        <= dvd_d;
            dsr_q        <= dsr_d;
            rem_q        <= rem_d;
            count_q      <= count_d;
            quotient_q   <= quotient_d;
            remainder_q  <= remainder_d;
            resp_id_q    <= resp_id_d;
            dbz_q        <= dbz_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.req0_ready  = ready0;
    assign bus.req1_ready  = ready1;
    assign bus.resp_valid  = (state_q == StDone);
    assign bus.resp_id     = resp_id_q;
    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.busy        = busy_q;
endmodule

// File: tb/tb_div_rr_sequencer.sv
// Bench for div_rr_sequencer: directed scenarios then randomized traffic,
// checked against an arithmetic reference and a round-robin grant model.
module tb_div_rr_sequencer;
    localparam int unsigned W = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    div_rr_sequencer_if #(.WIDTH(W)) bus ();

    div_rr_sequencer #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    bit lg_m = 1'b1;  // requester granted most recently, per the arbitration rule

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one or two requests, serve every one of them and check results.
    task automatic run(input bit v0, input bit v1,
                       input logic [W-1:0] a0, input logic [W-1:0] b0,
                       input logic [W-1:0] a1, input logic [W-1:0] b1,
                       input int hold, input bit rand_hold);
        bit pend0 = v0;
        bit pend1 = v1;
        bus.req0_valid    = v0;
        bus.req0_dividend = a0;
        bus.req0_divisor  = b0;
        bus.req1_valid    = v1;
        bus.req1_dividend = a1;
        bus.req1_divisor  = b1;
        while (pend0 || pend1) begin
            bit exp_id, r0, r1, got, sel, other;
            int n, lat, h;
            logic [W-1:0] a, b, eq, er;
            exp_id = (pend0 && pend1) ? !lg_m : pend1;
            got = 0;
            n = 0;
            r0 = 0;
            r1 = 0;
            while (!got && n < 8) begin
                #1;
                r0 = bus.req0_ready;
                r1 = bus.req1_ready;
                tick();
                if (r0 || r1) got = 1;
                else n++;
            end
            check("accept_delay", n, 0);
            if (!got) begin
                bus.req0_valid = 0;
                bus.req1_valid = 0;
                return;
            end
            check("grant_id", r1, exp_id);
            check("grant_onehot", r0 & r1, 0);
            sel  = r1;
            lg_m = sel;
            if (sel) begin
                bus.req1_valid = 0; pend1 = 0; a = a1; b = b1;
            end else begin
                bus.req0_valid = 0; pend0 = 0; a = a0; b = b0;
            end
            other = pend0 || pend1;
            eq = (b == 0) ? '1 : a / b;
            er = (b == 0) ? a : a % b;
            check("busy_after_accept", bus.busy, 1);
            lat = 0;
            while (!bus.resp_valid && lat < int'(W) + 4) begin
                bus.resp_ready = 1'($urandom_range(0, 1));  // ignored outside DONE
                tick();
                lat++;
            end
            bus.resp_ready = 0;
            check("latency", lat, (b == 0) ? 0 : W);
            check("quotient", bus.quotient, eq);
            check("remainder", bus.remainder, er);
            check("div_by_zero", bus.div_by_zero, (b == 0));
            check("resp_id", bus.resp_id, sel);
            h = rand_hold ? $urandom_range(0, hold) : hold;
            repeat (h) tick();
            #1;
            if (other) check("ready_in_done", bus.req0_ready | bus.req1_ready, 0);
            check("hold_valid", bus.resp_valid, 1);
            check("hold_quotient", bus.quotient, eq);
            check("hold_remainder", bus.remainder, er);
            check("hold_id", bus.resp_id, sel);
            bus.resp_ready = 1;
            tick();
            bus.resp_ready = 0;
            check("post_hs_valid", bus.resp_valid, 0);
            check("post_hs_busy", bus.busy, 0);
            check("post_hs_dbz", bus.div_by_zero, 0);
            check("post_hs_quotient", bus.quotient, eq);
        end
    endtask

    function automatic logic [W-1:0] rand_divisor();
        int k = $urandom_range(0, 9);
        if (k == 0) return '0;
        if (k < 4) return W'($urandom_range(1, 15));
        if (k < 6) return W'($urandom) >> $urandom_range(0, 31);
        return W'($urandom);
    endfunction

    initial begin
        bit seen;
        bus.req0_valid = 0; bus.req0_dividend = '0; bus.req0_divisor = '0;
        bus.req1_valid = 0; bus.req1_dividend = '0; bus.req1_divisor = '0;
        bus.resp_ready = 0;

        // Reset state, with a requester valid to confirm ready is held low.
        tick();
        bus.req0_valid = 1;
        #1;
        check("rst_ready0", bus.req0_ready, 0);
        check("rst_resp_valid", bus.resp_valid, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_quotient", bus.quotient, 0);
        check("rst_remainder", bus.remainder, 0);
        check("rst_dbz", bus.div_by_zero, 0);
        check("rst_id", bus.resp_id, 0);
        bus.req0_valid = 0;
        tick();
        rst_n = 1;
        tick();

        // Simultaneous pairs from reset, then a third pair to show alternation.
        run(1, 1, 50, 5, 50, 5, 0, 0);
        run(1, 1, 50, 5, 50, 5, 0, 0);
        run(1, 1, 90, 9, 77, 11, 0, 0);
        // Single requester, simple divide.
        run(1, 0, 100, 7, 0, 0, 0, 0);
        // Divide by zero on requester 1.
        run(0, 1, 0, 0, 32'h1234_5678, 0, 0, 0);
        // Backpressure: response held 5 cycles while the other requester waits.
        run(1, 1, 1000, 3, 32'hDEAD_BEEF, 16, 5, 0);

        // Reset during an operation: no stale response afterwards.
        bus.req0_dividend = '1;
        bus.req0_divisor  = 1;
        bus.req0_valid    = 1;
        tick();
        bus.req0_valid = 0;
        check("mid_busy", bus.busy, 1);
        repeat (10) tick();
        bus.req0_valid = 1;
        rst_n = 0;
        #1;
        check("mid_rst_resp_valid", bus.resp_valid, 0);
        check("mid_rst_busy", bus.busy, 0);
        check("mid_rst_quotient", bus.quotient, 0);
        check("mid_rst_remainder", bus.remainder, 0);
        check("mid_rst_ready0", bus.req0_ready, 0);
        bus.req0_valid = 0;
        tick();
        tick();
        rst_n = 1;
        lg_m = 1;
        seen = 0;
        repeat (40) begin
            tick();
            if (bus.resp_valid) seen = 1;
        end
        check("no_stale_resp", seen, 0);
        run(1, 0, '1, 1, 0, 0, 0, 0);

        // Random traffic with random response backpressure and idle gaps.
        for (int t = 0; t < 40; t++) begin
            int p = $urandom_range(0, 2);
            run(p != 1, p != 0, W'($urandom), rand_divisor(), W'($urandom), rand_divisor(), 4, 1);
            repeat ($urandom_range(0, 3)) tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
